imu_rate_averager: RTL and testbench

IMU_RATE_AVERAGER -- requirements
Module: imu_rate_averager

---
 rtl/imu_rate_averager_pkg.sv | 21 ++
 rtl/imu_rate_averager_window.sv | 68 ++++++
 rtl/imu_rate_averager.sv | 155 +++++++++++++++
 tb/tb_imu_rate_averager.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_rate_averager_pkg.sv
// Shared definitions for the IMU rate averager and its i2c_device_driver peer:
// control FSM state encoding and common width defaults.
package imu_rate_averager_pkg;

  // Gyro sample width shared with i2c_device_driver.
  localparam int DATA_W_DEFAULT   = 16;
  // Default averaging window is 2^2 = 4 samples.
  localparam int AVG_LOG2_DEFAULT = 2;

  // Saturation value of the dropped-strobe counter.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Control FSM states; only ST_IDLE accepts a new strobe.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_OUTPUT = 2'd2,
    ST_ACK    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/imu_rate_averager_window.sv
// rate_window_accum: one axis of the moving-average window. Holds the sample
// ring, the running sum and the latched average. The write pointer is owned by
// the top level so all three axes stay in lockstep.
module rate_window_accum
  import imu_rate_averager_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int AVG_LOG2 = AVG_LOG2_DEFAULT
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic                       latch_en_i,
  input  logic [AVG_LOG2-1:0]        wr_ptr_i,
  input  logic signed [DATA_W-1:0]   sample_i,
  output logic signed [DATA_W-1:0]   avg_o
);

  localparam int N     = 1 << AVG_LOG2;
  // N samples of DATA_W bits can never overflow DATA_W+AVG_LOG2 bits.
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic signed [DATA_W-1:0] ring_q [N];
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  new_ext;
  logic signed [SUM_W-1:0]  old_ext;
  logic signed [DATA_W-1:0] avg_q;
  logic signed [DATA_W-1:0] avg_d;

  // Next running sum: add the incoming sample, retire the one it overwrites.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    new_ext = sample_i;
    old_ext = ring_q[wr_ptr_i];
    sum_d   = sum_q;
    if (wr_en_i) begin
      sum_d = sum_q + new_ext - old_ext;
    end
    // Arithmetic shift floors toward -inf; the result always fits DATA_W.
    avg_d = DATA_W'(sum_d >>> AVG_LOG2);
  end

  // Ring, sum and average registers.
  // NOTE: the ring is reset explicitly because a freshly reset window must
  // average as zeros; this costs reset muxes on every entry.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        ring_q[i] <= '0;
      end
      sum_q <= '0;
      avg_q <= '0;
    end else begin
      if (wr_en_i) begin
        ring_q[wr_ptr_i] <= sample_i;
      end
      sum_q <= sum_d;
      if (latch_en_i) begin
        avg_q <= avg_d;
      end
    end
  end

  assign avg_o = avg_q;

endmodule

// File: rtl/imu_rate_averager.sv
// imu_rate_averager: three-axis moving average of gyro rates with a
// valid/ready output handshake and a next-read pulse back to the I2C driver.
module imu_rate_averager
  import imu_rate_averager_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int AVG_LOG2 = AVG_LOG2_DEFAULT
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     valid_strobe,
  input  logic signed [DATA_W-1:0] gyro_rate_x,
  input  logic signed [DATA_W-1:0] gyro_rate_y,
  input  logic signed [DATA_W-1:0] gyro_rate_z,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] avg_rate_x,
  output logic signed [DATA_W-1:0] avg_rate_y,
  output logic signed [DATA_W-1:0] avg_rate_z,
  output logic                     out_valid,
  output logic                     next_mod_active,
  output logic                     primed,
  output logic [7:0]               dropped_count
);

  localparam int                N         = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(N);

  ctrl_state_e state_q, state_d;

  logic signed [DATA_W-1:0] hold_x_q, hold_y_q, hold_z_q;
  logic [AVG_LOG2-1:0]      wr_ptr_q;
  logic [AVG_LOG2:0]        fill_q;
  logic [7:0]               dropped_q;

  logic capture;
  logic update;
  logic latch_avg;
  logic fills_window;
  logic drop;

  // The write in this UPDATE completes the window if fill is already N-1 or N.
  assign fills_window = (fill_q == FILL_FULL) || (fill_q == FILL_FULL - 1'b1);
  assign drop         = valid_strobe && (state_q != ST_IDLE);

  // Control FSM next state and per-state strobes.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    update    = 1'b0;
    latch_avg = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_strobe) begin
          capture = 1'b1;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        update = 1'b1;
        if (fills_window) begin
          latch_avg = 1'b1;
          state_d   = ST_OUTPUT;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, holding registers, window bookkeeping and drop counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_x_q  <= '0;
      hold_y_q  <= '0;
      hold_z_q  <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_x_q <= gyro_rate_x;
        hold_y_q <= gyro_rate_y;
        hold_z_q <= gyro_rate_z;
      end
      if (update) begin
        // N is a power of two, so the pointer wraps naturally.
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != FILL_FULL) begin
          fill_q <= fill_q + 1'b1;
        end
      end
      if (drop && (dropped_q != DROP_MAX)) begin
        dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  rate_window_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc_x (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .wr_en_i    (update),
    .latch_en_i (latch_avg),
    .wr_ptr_i   (wr_ptr_q),
    .sample_i   (hold_x_q),
    .avg_o      (avg_rate_x)
  );

  rate_window_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc_y (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .wr_en_i    (update),
    .latch_en_i (latch_avg),
    .wr_ptr_i   (wr_ptr_q),
    .sample_i   (hold_y_q),
    .avg_o      (avg_rate_y)
  );

  rate_window_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc_z (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .wr_en_i    (update),
    .latch_en_i (latch_avg),
    .wr_ptr_i   (wr_ptr_q),
    .sample_i   (hold_z_q),
    .avg_o      (avg_rate_z)
  );

  assign out_valid       = (state_q == ST_OUTPUT);
  assign next_mod_active = (state_q == ST_ACK);
  assign primed          = (fill_q == FILL_FULL);
  assign dropped_count   = dropped_q;

endmodule

// File: tb/tb_imu_rate_averager.sv
// Testbench for imu_rate_averager: directed scenarios plus randomized samples,
// checked against a window model built from plain integer arithmetic.
module tb_imu_rate_averager;

  localparam int DATA_W   = 16;
  localparam int AVG_LOG2 = 2;
  localparam int N        = 1 << AVG_LOG2;

  logic                     sys_clk = 1'b0;
  logic                     reset;
  logic                     valid_strobe;
  logic signed [DATA_W-1:0] gx, gy, gz;
  logic                     out_ready;
  logic signed [DATA_W-1:0] ax, ay, az;
  logic                     out_valid;
  logic                     nma;
  logic                     primed;
  logic [7:0]               dropped;

  int pass_count  = 0;
  int check_count = 0;

  // Window model: last N samples per axis, fill level, expected latched avg.
  int win [3][N];
  int m_wptr;
  int m_fill;
  int exp_avg [3];
  bit exp_primed;

  imu_rate_averager #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .valid_strobe    (valid_strobe),
    .gyro_rate_x     (gx),
    .gyro_rate_y     (gy),
    .gyro_rate_z     (gz),
    .out_ready       (out_ready),
    .avg_rate_x      (ax),
    .avg_rate_y      (ay),
    .avg_rate_z      (az),
    .out_valid       (out_valid),
    .next_mod_active (nma),
    .primed          (primed),
    .dropped_count   (dropped)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input longint act, input longint exp);
    check_count++;
    if (act == exp) pass_count++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int floor_div(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      for (int i = 0; i < N; i++) win[a][i] = 0;
      exp_avg[a] = 0;
    end
    m_wptr     = 0;
    m_fill     = 0;
    exp_primed = 1'b0;
  endtask

  task automatic model_push(input int x, input int y, input int z);
    win[0][m_wptr] = x;
    win[1][m_wptr] = y;
    win[2][m_wptr] = z;
    m_wptr = (m_wptr + 1) % N;
    if (m_fill < N) m_fill++;
    exp_primed = (m_fill == N);
    if (exp_primed) begin
      for (int a = 0; a < 3; a++) begin
        int s = 0;
        for (int i = 0; i < N; i++) s += win[a][i];
        exp_avg[a] = floor_div(s);
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One full transaction from IDLE back to IDLE, checking the handshake timing.
  task automatic send(input int x, input int y, input int z, input int rdy_delay);
    model_push(x, y, z);
    out_ready    = (rdy_delay == 0);
    valid_strobe = 1'b1;
    gx = 16'(x);
    gy = 16'(y);
    gz = 16'(z);
    tick();
    valid_strobe = 1'b0;
    check("update_no_valid", out_valid, 0);
    tick();
    if (exp_primed) begin
      check("latency_valid", out_valid, 1);
      for (int i = 0; i < rdy_delay; i++) begin
        tick();
        check("hold_valid", out_valid, 1);
        check("hold_no_ack", nma, 0);
      end
      out_ready = 1'b1;
      tick();
      check("ack_pulse", nma, 1);
      check("ack_clears_valid", out_valid, 0);
    end else begin
      check("unprimed_no_valid", out_valid, 0);
      check("unprimed_ack", nma, 1);
      check("unprimed_flag", primed, 0);
    end
    tick();
    check("ack_single", nma, 0);
  endtask

  // Whenever a sample is presented it must match the model's window average.
  always @(negedge sys_clk) begin
    if (out_valid === 1'b1) begin
      check("cmp_avg_x", ax, exp_avg[0]);
      check("cmp_avg_y", ay, exp_avg[1]);
      check("cmp_avg_z", az, exp_avg[2]);
      check("cmp_primed", primed, 1);
      check("cmp_no_ack_with_valid", nma, 0);
    end
  end

  initial begin
    logic signed [DATA_W-1:0] r;
    reset        = 1'b1;
    valid_strobe = 1'b0;
    out_ready    = 1'b1;
    gx = '0;
    gy = '0;
    gz = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_nma", nma, 0);
    check("rst_primed", primed, 0);
    check("rst_dropped", dropped, 0);
    check("rst_avg_x", ax, 0);
    check("rst_avg_y", ay, 0);
    check("rst_avg_z", az, 0);

    // First three samples fill the window silently; the fourth averages 250.
    send(100, 0, 0, 0);
    send(200, 0, 0, 0);
    send(300, 0, 0, 0);
    send(400, 0, 0, 0);
    check("fill_avg_x_250", ax, 250);
    check("fill_primed", primed, 1);

    // Wrap-around: -400 replaces 100, then 500 replaces 200.
    send(-400, 0, 0, 0);
    check("wrap_avg_x_125", ax, 125);
    send(500, 0, 0, 0);
    check("wrap_avg_x_200", ax, 200);

    // Fresh window, negative floor: sum -5 averages to -2.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("rst2_primed", primed, 0);
    send(0, -1, 0, 0);
    send(0, -1, 0, 0);
    send(0, -1, 0, 0);
    send(0, -2, 0, 0);
    check("floor_avg_y_m2", ay, -2);

    // Backpressure for 20 cycles.
    send(10, 20, 30, 20);

    // Strobes in UPDATE and ACK are dropped and never enter the window.
    model_push(1000, 0, 0);
    out_ready    = 1'b1;
    valid_strobe = 1'b1;
    gx = 16'sd1000;
    gy = '0;
    gz = '0;
    tick();
    gx = 16'sd9999;
    tick();
    valid_strobe = 1'b0;
    tick();
    check("drop_ack_pulse", nma, 1);
    valid_strobe = 1'b1;
    gx = 16'sd7777;
    tick();
    valid_strobe = 1'b0;
    check("drop_count_2", dropped, 2);
    check("drop_ack_single", nma, 0);
    send(0, 0, 0, 0);
    check("drop_window_x_252", ax, 252);

    // 300 strobes while stalled in OUTPUT saturate the drop counter.
    model_push(5, 5, 5);
    out_ready    = 1'b0;
    valid_strobe = 1'b1;
    gx = 16'sd5;
    gy = 16'sd5;
    gz = 16'sd5;
    tick();
    gx = -16'sd1234;
    repeat (300) tick();
    check("drop_saturate", dropped, 255);
    check("drop_stall_valid", out_valid, 1);
    valid_strobe = 1'b0;
    out_ready    = 1'b1;
    tick();
    check("drop_stall_ack", nma, 1);
    tick();

    // Reset while presenting a sample aborts the transaction.
    model_push(77, 77, 77);
    out_ready    = 1'b0;
    valid_strobe = 1'b1;
    gx = 16'sd77;
    gy = 16'sd77;
    gz = 16'sd77;
    tick();
    valid_strobe = 1'b0;
    tick();
    check("abort_in_output", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("abort_valid", out_valid, 0);
    check("abort_primed", primed, 0);
    check("abort_avg_x", ax, 0);
    check("abort_nma", nma, 0);
    check("abort_dropped", dropped, 0);
    tick();
    check("abort_no_ack", nma, 0);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(8, 8, 8, 0);
    check("abort_avg8_x", ax, 8);
    check("abort_avg8_y", ay, 8);
    check("abort_avg8_z", az, 8);

    // Extremes of the sample range.
    for (int i = 0; i < N; i++) send(-32768, 32767, 0, 0);
    check("min_avg_x", ax, -32768);
    check("max_avg_y", ay, 32767);

    // Randomized samples with random backpressure.
    for (int k = 0; k < 60; k++) begin
      int x, y, z;
      r = 16'($urandom);
      x = int'(r);
      r = 16'($urandom);
      y = int'(r);
      r = 16'($urandom);
      z = int'(r);
      send(x, y, z, int'($urandom_range(0, 3)));
    end
    check("rand_final_x", ax, exp_avg[0]);
    check("rand_dropped", dropped, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
